serial_subtractor: RTL and testbench

- Bit-serial subtractor; the inverse operation of the team's full-adder datapath.
- Accepts two WIDTH-bit operands and a borrow-in through a valid/ready handshake.
- Computes A - B - bin LSB-first, one bit per clock, through a 1-bit full-subtractor cell and a borrow register.
- Returns difference, borrow-out and signed overflow through a second valid/ready handshake. Sits between an operand source and a result consumer in the arithmetic verification datapath.

---
 rtl/serial_arith_pkg.sv | 12 +
 rtl/full_subtractor.sv | 13 +
 rtl/serial_subtractor.sv | 104 ++++++++++
 tb/tb_serial_subtractor.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/serial_arith_pkg.sv
// Shared types and constants for the bit-serial arithmetic blocks.
package serial_arith_pkg;

   typedef enum logic [1:0] {
      IDLE,
      SHIFT,
      DONE
   } ser_state_t;

   localparam int SER_WIDTH_DEF = 8;

endpackage

// File: rtl/full_subtractor.sv
// One-bit full-subtractor cell: difference and borrow-out of a - b - bin.
module full_subtractor (
   input  logic a,
   input  logic b,
   input  logic bin,
   output logic d,
   output logic bo
);

   assign d  = a ^ b ^ bin;
   assign bo = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: computes A - B - bin LSB-first, one bit per clock,
// with valid/ready handshakes on both the operand and result sides.
module serial_subtractor
   import serial_arith_pkg::*;
#(
   parameter int WIDTH = SER_WIDTH_DEF,
   parameter int CNT_W = $clog2(WIDTH + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_a,
   input  logic [WIDTH-1:0] in_b,
   input  logic             in_bin,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] diff,
   output logic             bout,
   output logic             ovf
);

   ser_state_t       state;
   logic [CNT_W-1:0] cnt;
   logic [WIDTH-1:0] a_sr;
   logic [WIDTH-1:0] b_sr;
   logic [WIDTH-1:0] res_sr;
   logic             borrow;
   logic             a_sign;
   logic             b_sign;

   logic             cell_d;
   logic             cell_bo;
   logic             accept;
   logic             last_bit;
   logic [WIDTH-1:0] res_next;

   full_subtractor u_cell (
      .a   (a_sr[0]),
      .b   (b_sr[0]),
      .bin (borrow),
      .d   (cell_d),
      .bo  (cell_bo)
   );

   assign in_ready = (state == IDLE) || ((state == DONE) && out_ready);
   assign accept   = in_valid && in_ready;
   assign last_bit = (cnt == CNT_W'(WIDTH - 1));

   // New difference bits enter from the MSB so the LSB-first stream lands in place.
   assign res_next = (res_sr >> 1) | {cell_d, {(WIDTH-1){1'b0}}};

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         cnt       <= '0;
         a_sr      <= '0;
         b_sr      <= '0;
         res_sr    <= '0;
         borrow    <= 1'b0;
         a_sign    <= 1'b0;
         b_sign    <= 1'b0;
         diff      <= '0;
         bout      <= 1'b0;
         ovf       <= 1'b0;
         out_valid <= 1'b0;
      end else if (accept) begin
         a_sr      <= in_a;
         b_sr      <= in_b;
         borrow    <= in_bin;
         a_sign    <= in_a[WIDTH-1];
         b_sign    <= in_b[WIDTH-1];
         cnt       <= '0;
         out_valid <= 1'b0;
         state     <= SHIFT;
      end else begin
         case (state)
            SHIFT: begin
               a_sr   <= a_sr >> 1;
               b_sr   <= b_sr >> 1;
               res_sr <= res_next;
               borrow <= cell_bo;
               cnt    <= cnt + CNT_W'(1);
               // Overflow uses the sign bits captured at accept time.
               if (last_bit) begin
                  diff      <= res_next;
                  bout      <= cell_bo;
                  ovf       <= (a_sign != b_sign) && (cell_d != a_sign);
                  out_valid <= 1'b1;
                  state     <= DONE;
               end
            end
            DONE: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  state     <= IDLE;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor: directed table, corner sequences
// and a randomised sweep against an arithmetic reference model.
module tb_serial_subtractor;

   localparam int W = 8;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         in_valid = 1'b0;
   logic         in_ready;
   logic [W-1:0] in_a = '0;
   logic [W-1:0] in_b = '0;
   logic         in_bin = 1'b0;
   logic         out_valid;
   logic         out_ready = 1'b0;
   logic [W-1:0] diff;
   logic         bout;
   logic         ovf;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [7:0] a;
      logic [7:0] b;
      logic       bin;
      logic [7:0] d;
      logic       bo;
      logic       ov;
   } vec_t;

   typedef struct {
      logic [7:0] d;
      logic       bo;
      logic       ov;
   } res_t;

   serial_subtractor #(.WIDTH(W)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_a      (in_a),
      .in_b      (in_b),
      .in_bin    (in_bin),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .diff      (diff),
      .bout      (bout),
      .ovf       (ovf)
   );

   always #5 clk = ~clk;

   // Reference: plain unsigned and signed arithmetic on the operands.
   function automatic res_t model(logic [7:0] a, logic [7:0] b, logic bin);
      res_t m;
      int ua, ub, sa, sb, r;
      ua = int'(a);
      ub = int'(b);
      sa = int'($signed(a));
      sb = int'($signed(b));
      r  = sa - sb - int'(bin);
      m.d  = 8'(ua - ub - int'(bin));
      m.bo = (ua < ub + int'(bin));
      m.ov = (r < -128) || (r > 127);
      return m;
   endfunction

   task automatic checkOutput(string name, logic [31:0] actual, logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s actual=%0h expected=%0h", name, actual, expected);
      end
   endtask

   // Present one operand set, wait for its result, report it and consume it.
   task automatic applyStimulus(input logic [7:0] a, input logic [7:0] b, input logic bin,
                                output res_t r, output int lat);
      int n;
      @(negedge clk);
      in_a      = a;
      in_b      = b;
      in_bin    = bin;
      in_valid  = 1'b1;
      out_ready = 1'b0;
      n = 0;
      while (!in_ready && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (n >= 100) checkOutput("in_ready_wait", 32'(in_ready), 32'd1);
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      lat = 0;
      while (!out_valid && lat < 100) begin
         @(posedge clk);
         lat++;
         @(negedge clk);
      end
      r.d  = diff;
      r.bo = bout;
      r.ov = ovf;
      out_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      out_ready = 1'b0;
   endtask

   initial begin
      vec_t vecs[5];
      res_t r, e;
      res_t exp_q[$];
      int   lat, n, sent, rcvd, cyc;
      bit   pending, stable;
      logic [7:0] held_d;
      logic       held_bo;

      vecs[0] = '{a: 8'h5A, b: 8'h3C, bin: 1'b0, d: 8'h1E, bo: 1'b0, ov: 1'b0};
      vecs[1] = '{a: 8'h00, b: 8'h01, bin: 1'b0, d: 8'hFF, bo: 1'b1, ov: 1'b0};
      vecs[2] = '{a: 8'h80, b: 8'h01, bin: 1'b0, d: 8'h7F, bo: 1'b0, ov: 1'b1};
      vecs[3] = '{a: 8'h10, b: 8'h0F, bin: 1'b1, d: 8'h00, bo: 1'b0, ov: 1'b0};
      vecs[4] = '{a: 8'h00, b: 8'h80, bin: 1'b1, d: 8'h7F, bo: 1'b1, ov: 1'b0};

      // Reset state
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;
      checkOutput("reset_in_ready", 32'(in_ready), 32'd1);
      checkOutput("reset_out_valid", 32'(out_valid), 32'd0);
      checkOutput("reset_outputs", {22'd0, diff, bout, ovf}, 32'd0);

      // Directed table
      for (int i = 0; i < 5; i++) begin
         applyStimulus(vecs[i].a, vecs[i].b, vecs[i].bin, r, lat);
         checkOutput($sformatf("vec%0d_latency", i), 32'(lat), 32'd8);
         checkOutput($sformatf("vec%0d_result", i), {22'd0, r.d, r.bo, r.ov},
                     {22'd0, vecs[i].d, vecs[i].bo, vecs[i].ov});
      end

      // Backpressure in DONE followed by a same-edge handoff
      @(negedge clk);
      in_a = 8'h5A; in_b = 8'h3C; in_bin = 1'b0; in_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      n = 0;
      while (!out_valid && n < 100) begin
         @(negedge clk);
         n++;
      end
      held_d  = diff;
      held_bo = bout;
      stable  = 1'b1;
      for (int i = 0; i < 5; i++) begin
         if (!out_valid || diff !== held_d || bout !== held_bo || in_ready !== 1'b0) stable = 1'b0;
         @(negedge clk);
      end
      checkOutput("bp_stable", 32'(stable), 32'd1);
      checkOutput("bp_result", {23'd0, held_d, held_bo}, {23'd0, 8'h1E, 1'b0});
      in_a = 8'h80; in_b = 8'h01; in_bin = 1'b0;
      in_valid = 1'b1; out_ready = 1'b1;
      #1;
      checkOutput("bp_handoff_ready", 32'(in_ready), 32'd1);
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0; out_ready = 1'b0;
      checkOutput("bp_consumed", 32'(out_valid), 32'd0);
      lat = 0;
      while (!out_valid && lat < 100) begin
         @(posedge clk);
         lat++;
         @(negedge clk);
      end
      checkOutput("bp_next_latency", 32'(lat), 32'd8);
      checkOutput("bp_next_result", {22'd0, diff, bout, ovf}, {22'd0, 8'h7F, 1'b0, 1'b1});
      out_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      out_ready = 1'b0;

      // Reset in the third SHIFT cycle aborts the operation
      in_a = 8'h33; in_b = 8'h11; in_bin = 1'b0; in_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      checkOutput("abort_out_valid", 32'(out_valid), 32'd0);
      checkOutput("abort_outputs", {22'd0, diff, bout, ovf}, 32'd0);
      checkOutput("abort_in_ready", 32'(in_ready), 32'd1);
      applyStimulus(8'hFF, 8'hFF, 1'b0, r, lat);
      checkOutput("abort_follow_latency", 32'(lat), 32'd8);
      checkOutput("abort_follow_result", {23'd0, r.d, r.bo}, 32'd0);

      // Randomised sweep with handshake gaps on both sides
      sent = 0; rcvd = 0; cyc = 0; pending = 1'b0;
      while (rcvd < 200 && cyc < 20000) begin
         @(negedge clk);
         cyc++;
         if (!pending && sent < 200 && $urandom_range(0, 2) != 0) begin
            pending = 1'b1;
            in_a    = 8'($urandom);
            in_b    = 8'($urandom);
            in_bin  = 1'($urandom);
         end
         in_valid  = pending;
         out_ready = ($urandom_range(0, 3) != 0);
         #1;
         if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
               checkOutput("sweep_spurious", 32'd1, 32'd0);
            end else begin
               e = exp_q.pop_front();
               checkOutput($sformatf("sweep_result%0d", rcvd), {22'd0, diff, bout, ovf},
                           {22'd0, e.d, e.bo, e.ov});
               rcvd++;
            end
         end
         if (in_valid && in_ready) begin
            exp_q.push_back(model(in_a, in_b, in_bin));
            sent++;
            pending = 1'b0;
         end
      end
      @(negedge clk);
      in_valid = 1'b0;
      out_ready = 1'b0;
      checkOutput("sweep_count", 32'(rcvd), 32'd200);
      checkOutput("sweep_leftover", 32'(exp_q.size()), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
